// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-port ALU sharing arbiter.
package alu_share_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    // ALU operation codes; the arbiter forwards these verbatim, including unused codes 9..15
    typedef enum logic [OP_W-1:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_XOR = 4'd3,
        OP_NOR = 4'd4,
        OP_SRL = 4'd5,
        OP_SUB = 4'd6,
        OP_SLT = 4'd7,
        OP_SLL = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's request/response channel pair into the ALU sharing arbiter.
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int OPW   = OP_W
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [OPW-1:0]   req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_res;
    logic             rsp_zero;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_ovf
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: the port not served last wins a tie.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_served,
    output logic [1:0] grant
);

    // One-hot grant: sole requester, or the port after last_served on contention
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_served ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters, one operation in flight at a time.
//
// state | meaning
// IDLE  | waiting for a request; ready asserted to the granted port only
// EXEC  | operands driven to the ALU, counting down to result capture
// RESP  | result held on the owner's response channel until consumed
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int OPW     = OP_W,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   port0,
    alu_share_arbiter_if.slave   port1,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [OPW-1:0]       alu_op,
    input  logic [WIDTH-1:0]     alu_res,
    input  logic                 alu_zero,
    input  logic                 alu_ovf
);

    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       req_valid, rsp_ready, grant, req_ready;
    logic             last_q, owner_q;
    logic [3:0]       cnt_q;
    logic             accept, capture, release_op;
    logic [1:0]       rsp_valid_q, rsp_zero_q, rsp_ovf_q;
    logic [WIDTH-1:0] rsp_res_q [2];

    assign req_valid = {port1.req_valid, port0.req_valid};
    assign rsp_ready = {port1.rsp_ready, port0.rsp_ready};

    assign port0.req_ready = req_ready[0];
    assign port1.req_ready = req_ready[1];
    assign port0.rsp_valid = rsp_valid_q[0];
    assign port1.rsp_valid = rsp_valid_q[1];
    assign port0.rsp_res   = rsp_res_q[0];
    assign port1.rsp_res   = rsp_res_q[1];
    assign port0.rsp_zero  = rsp_zero_q[0];
    assign port1.rsp_zero  = rsp_zero_q[1];
    assign port0.rsp_ovf   = rsp_ovf_q[0];
    assign port1.rsp_ovf   = rsp_ovf_q[1];

    rr_arb2 u_rr_arb2 (
        .valid       (req_valid),
        .last_served (last_q),
        .grant       (grant)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, request ready and datapath strobes; ready is masked while in reset
    always_comb begin
        state_d    = state_q;
        req_ready  = 2'b00;
        accept     = 1'b0;
        capture    = 1'b0;
        release_op = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    req_ready = grant;
                    if (grant != 2'b00) begin
                        accept  = 1'b1;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    release_op = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Launch the accepted operands to the ALU and remember who owns the op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            owner_q <= 1'b0;
        end else if (accept) begin
            owner_q <= grant[1];
            alu_a   <= grant[1] ? port1.req_a  : port0.req_a;
            alu_b   <= grant[1] ? port1.req_b  : port0.req_b;
            alu_op  <= grant[1] ? port1.req_op : port0.req_op;
        end
    end

    // Cycles elapsed since the operands were registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   cnt_q <= '0;
        else if (accept)           cnt_q <= '0;
        else if (state_q == EXEC)  cnt_q <= cnt_q + 4'd1;
    end

    // Result capture into the owner's response registers and response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 2'b00;
            rsp_zero_q   <= 2'b00;
            rsp_ovf_q    <= 2'b00;
            rsp_res_q[0] <= '0;
            rsp_res_q[1] <= '0;
            last_q       <= 1'b1;
        end else begin
            if (capture) begin
                rsp_valid_q[owner_q] <= 1'b1;
                rsp_res_q[owner_q]   <= alu_res;
                rsp_zero_q[owner_q]  <= alu_zero;
                rsp_ovf_q[owner_q]   <= alu_ovf;
            end
            if (release_op) begin
                rsp_valid_q[owner_q] <= 1'b0;
                last_q               <= owner_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: reference ALU behind the arbiter, transaction-level model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int ALU_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_op;
    logic        alu_zero, alu_ovf;

    always #5 clk = ~clk;

    alu_share_arbiter_if p0 ();
    alu_share_arbiter_if p1 ();

    alu_share_arbiter #(.WIDTH(32), .OPW(4), .ALU_LAT(ALU_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .port0    (p0),
        .port1    (p1),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_res  (alu_res),
        .alu_zero (alu_zero),
        .alu_ovf  (alu_ovf)
    );

    // Reference ALU: {ovf, zero, res}
    function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_XOR: r = a ^ b;
            OP_NOR: r = ~(a | b);
            OP_SRL: r = a >> b[4:0];
            OP_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_SLT: r = {31'd0, $signed(a) < $signed(b)};
            OP_SLL: r = a << b[4:0];
            default: r = '0;
        endcase
        return {v, (r == 32'd0), r};
    endfunction

    assign {alu_ovf, alu_zero, alu_res} = alu_f(alu_a, alu_b, alu_op);

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: one op in flight, owner, edge at which it was accepted, expected result
    bit          m_busy;
    int          m_owner;
    int          m_acc_cyc;
    int          m_last;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [33:0] m_exp;
    logic [33:0] m_held [2];

    // Snapshot of the last pre-edge sample
    logic [1:0]  s_acc, s_rdy, s_rv, s_zero, s_ovf;
    logic [31:0] s_res [2];
    logic [31:0] s_alu_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        logic [1:0]  v, rdy_act, rv_act, rsp_rdy, rdy_exp;
        logic [31:0] res_act [2];
        logic [1:0]  z_act, o_act;
        logic        in_resp;
        logic [33:0] cur;
        v        = {p1.req_valid, p0.req_valid};
        rdy_act  = {p1.req_ready, p0.req_ready};
        rv_act   = {p1.rsp_valid, p0.rsp_valid};
        rsp_rdy  = {p1.rsp_ready, p0.rsp_ready};
        res_act[0] = p0.rsp_res;
        res_act[1] = p1.rsp_res;
        z_act    = {p1.rsp_zero, p0.rsp_zero};
        o_act    = {p1.rsp_ovf, p0.rsp_ovf};
        if (rst) begin
            m_busy = 0; m_last = 1; m_a = '0; m_b = '0; m_op = '0;
            m_held[0] = '0; m_held[1] = '0;
        end
        in_resp = m_busy && (cyc >= m_acc_cyc + ALU_LAT);
        rdy_exp = 2'b00;
        if (!rst && !m_busy) begin
            if (v == 2'b11) rdy_exp = (m_last == 1) ? 2'b01 : 2'b10;
            else            rdy_exp = v;
        end
        chk("req_ready", rdy_act, rdy_exp);
        for (int p = 0; p < 2; p++) begin
            cur = (in_resp && m_owner == p) ? m_exp : m_held[p];
            chk($sformatf("rsp%0d_valid", p), rv_act[p], (in_resp && m_owner == p));
            chk($sformatf("rsp%0d_res", p), res_act[p], cur[31:0]);
            chk($sformatf("rsp%0d_zero", p), z_act[p], cur[32]);
            chk($sformatf("rsp%0d_ovf", p), o_act[p], cur[33]);
        end
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
        if (!rst) begin
            if (!m_busy && rdy_exp != 2'b00) begin
                m_busy    = 1;
                m_owner   = rdy_exp[1] ? 1 : 0;
                m_acc_cyc = cyc + 1;
                m_a  = m_owner ? p1.req_a  : p0.req_a;
                m_b  = m_owner ? p1.req_b  : p0.req_b;
                m_op = m_owner ? p1.req_op : p0.req_op;
                m_exp = alu_f(m_a, m_b, m_op);
            end else if (in_resp && rsp_rdy[m_owner]) begin
                m_busy = 0;
                m_held[m_owner] = m_exp;
                m_last = m_owner;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        s_acc    = {p1.req_valid && p1.req_ready, p0.req_valid && p0.req_ready};
        s_rdy    = {p1.req_ready, p0.req_ready};
        s_rv     = {p1.rsp_valid, p0.rsp_valid};
        s_zero   = {p1.rsp_zero, p0.rsp_zero};
        s_ovf    = {p1.rsp_ovf, p0.rsp_ovf};
        s_res[0] = p0.rsp_res;
        s_res[1] = p1.rsp_res;
        s_alu_a  = alu_a;
        @(posedge clk);
        cyc++;
        #1;
        if (s_acc[0]) p0.req_valid = 1'b0;
        if (s_acc[1]) p1.req_valid = 1'b0;
    endtask

    task automatic set_req(input int port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (port == 0) begin
            p0.req_valid = 1'b1; p0.req_a = a; p0.req_b = b; p0.req_op = op;
        end else begin
            p1.req_valid = 1'b1; p1.req_a = a; p1.req_b = b; p1.req_op = op;
        end
    endtask

    task automatic wait_accept(input int port, input string name);
        logic got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            got = s_acc[port];
        end
        chk({name, "_accept"}, got, 1);
    endtask

    task automatic wait_rsp(input int port, input string name, output int n);
        logic got = 1'b0;
        n = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            n++;
            got = s_rv[port];
        end
        chk({name, "_rsp_valid"}, got, 1);
    endtask

    task automatic op_check(input int port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                            input logic [31:0] eres, input logic ez, input logic eo, input string name);
        int n;
        if (port == 0) p0.rsp_ready = 1'b1; else p1.rsp_ready = 1'b1;
        set_req(port, a, b, op);
        wait_accept(port, name);
        wait_rsp(port, name, n);
        chk({name, "_latency"}, n, ALU_LAT + 1);
        chk({name, "_res"}, s_res[port], eres);
        chk({name, "_zero"}, s_zero[port], ez);
        chk({name, "_ovf"}, s_ovf[port], eo);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        step();
        chk({name, "_rdy"}, s_rdy, 0);
        chk({name, "_rv"}, s_rv, 0);
        chk({name, "_res0"}, s_res[0], 0);
        chk({name, "_res1"}, s_res[1], 0);
        chk({name, "_alu_a"}, s_alu_a, 0);
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int order[$];
        int acc_at[$];
        logic [31:0] held_res;

        rst = 1'b1;
        p0.req_valid = 1'b0; p0.req_a = '0; p0.req_b = '0; p0.req_op = '0; p0.rsp_ready = 1'b0;
        p1.req_valid = 1'b0; p1.req_a = '0; p1.req_b = '0; p1.req_op = '0; p1.rsp_ready = 1'b0;
        m_busy = 0; m_last = 1; m_a = '0; m_b = '0; m_op = '0; m_owner = 0; m_acc_cyc = 0;
        m_exp = '0; m_held[0] = '0; m_held[1] = '0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // 1: single ADD on port 0
        op_check(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0, 1'b0, "t1_add");

        // 2: simultaneous requests after reset, port 0 first
        do_reset("t2_reset");
        p0.rsp_ready = 1'b1;
        p1.rsp_ready = 1'b1;
        set_req(0, 32'd3, 32'd3, OP_SUB);
        set_req(1, 32'hF0, 32'h0F, OP_OR);
        step();
        chk("t2_first_grant", s_acc, 2'b01);
        wait_rsp(0, "t2_p0", n);
        chk("t2_p0_res", s_res[0], 32'd0);
        chk("t2_p0_zero", s_zero[0], 1'b1);
        wait_accept(1, "t2_p1");
        wait_rsp(1, "t2_p1", n);
        chk("t2_p1_res", s_res[1], 32'hFF);

        // 3: overflow and signed compare
        op_check(0, 32'h7FFF_FFFF, 32'd1, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, "t3_add_ovf");
        op_check(1, 32'hFFFF_FFFB, 32'd2, OP_SLT, 32'd1, 1'b0, 1'b0, "t3_slt");

        // 4: response back-pressure on port 1 blocks port 0
        p1.rsp_ready = 1'b0;
        set_req(1, 32'd10, 32'd20, OP_ADD);
        wait_accept(1, "t4_p1");
        wait_rsp(1, "t4_p1", n);
        held_res = s_res[1];
        chk("t4_p1_res", held_res, 32'd30);
        p0.rsp_ready = 1'b1;
        set_req(0, 32'd1, 32'd2, OP_ADD);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_rsp1_valid_held", s_rv[1], 1'b1);
            chk("t4_rsp1_res_held", s_res[1], 32'd30);
            chk("t4_req0_ready_low", s_rdy[0], 1'b0);
        end
        p1.rsp_ready = 1'b1;
        wait_accept(0, "t4_p0");
        wait_rsp(0, "t4_p0", n);
        chk("t4_p0_res", s_res[0], 32'd3);

        // 5: both continuously valid -> strict alternation at peak rate
        set_req(0, $urandom, $urandom, OP_ADD);
        set_req(1, $urandom, $urandom, OP_XOR);
        for (int i = 0; i < 100 && order.size() < 8; i++) begin
            step();
            if (s_acc[0]) begin order.push_back(0); acc_at.push_back(cyc); set_req(0, $urandom, $urandom, OP_SUB); end
            if (s_acc[1]) begin order.push_back(1); acc_at.push_back(cyc); set_req(1, $urandom, $urandom, OP_NOR); end
        end
        chk("t5_ops", order.size(), 8);
        if (order.size() > 0) chk("t5_first_grant", order[0], 1);
        for (int i = 1; i < order.size(); i++) begin
            chk("t5_alternate", order[i], 1 - order[i-1]);
            chk("t5_spacing", acc_at[i] - acc_at[i-1], ALU_LAT + 2);
        end
        p0.req_valid = 1'b0;
        p1.req_valid = 1'b0;
        repeat (5) step();

        // 6: reset during EXEC discards the op
        set_req(0, 32'd9, 32'd9, OP_ADD);
        wait_accept(0, "t6_p0");
        do_reset("t6_reset");
        op_check(0, 32'd1, 32'd1, OP_ADD, 32'd2, 1'b0, 1'b0, "t6_after");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (!p0.req_valid && $urandom_range(0, 2) == 0)
                set_req(0, rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
            if (!p1.req_valid && $urandom_range(0, 2) == 0)
                set_req(1, rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
            p0.rsp_ready = ($urandom_range(0, 3) != 0);
            p1.rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        p0.req_valid = 1'b0;
        p1.req_valid = 1'b0;
        p0.rsp_ready = 1'b1;
        p1.rsp_ready = 1'b1;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
